mips_exec_stage: RTL and testbench

Single-cycle MIPS-subset execute block combining three parts:
- instruction decoder (field split plus control signals);
- 32-bit ALU with operand-B immediate mux;
- word-addressed data memory with writeback-data mux.

It sits between the register file and the PC/writeback logic of the single-cycle core. Register file, PC and next-PC logic are outside this block.

---
 rtl/mips_exec_stage.sv | 149 ++++++++++++++
 tb/tb_mips_exec_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_exec_stage.sv
// Single-cycle MIPS-subset execute block: decoder, 32-bit ALU and word-addressed
// data memory with the writeback-data mux.
module mips_exec_stage #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm,
  output logic [25:0] adr,
  output logic        regwrite,
  output logic        memwrite,
  output logic        memread,
  output logic        branch,
  output logic        jump,
  output logic [3:0]  alu_op,
  output logic        imm_sel,
  output logic        reg_dst,
  output logic [4:0]  write_reg,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data
);
  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0]   mem [MEM_DEPTH];
  logic [31:0]   ext_imm;
  logic [31:0]   opb;
  logic [AW-1:0] idx;
  logic          unused_addr_bits;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];
  assign adr    = instruction[25:0];

  always_comb begin
    regwrite = 1'b0;
    memwrite = 1'b0;
    memread  = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    alu_op   = 4'd0;
    imm_sel  = 1'b0;
    reg_dst  = 1'b0;
    case (opcode)
      6'h00: begin
        reg_dst  = 1'b1;
        regwrite = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = 4'd0;
          6'h22, 6'h23: alu_op = 4'd1;
          6'h24:        alu_op = 4'd2;
          6'h25:        alu_op = 4'd3;
          6'h26:        alu_op = 4'd4;
          6'h27:        alu_op = 4'd5;
          6'h2A:        alu_op = 4'd6;
          6'h2B:        alu_op = 4'd7;
          6'h00:        alu_op = 4'd8;
          6'h02:        alu_op = 4'd9;
          6'h03:        alu_op = 4'd10;
          default:      regwrite = 1'b0;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        regwrite = 1'b1;
        imm_sel  = 1'b1;
        case (opcode)
          6'h0A:   alu_op = 4'd6;
          6'h0B:   alu_op = 4'd7;
          6'h0C:   alu_op = 4'd2;
          6'h0D:   alu_op = 4'd3;
          6'h0E:   alu_op = 4'd4;
          6'h0F:   alu_op = 4'd11;
          default: alu_op = 4'd0;
        endcase
      end
      6'h23: begin
        regwrite = 1'b1;
        memread  = 1'b1;
        imm_sel  = 1'b1;
      end
      6'h2B: begin
        memwrite = 1'b1;
        imm_sel  = 1'b1;
      end
      6'h04: begin
        branch = 1'b1;
        alu_op = 4'd1;
      end
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  // Logical immediates zero-extend; everything else sign-extends.
  assign ext_imm = (opcode == 6'h0C || opcode == 6'h0D || opcode == 6'h0E) ?
                   {16'h0000, imm} : {{16{imm[15]}}, imm};
  assign opb = imm_sel ? ext_imm : rt_data;

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      4'd0:    alu_result = rs_data + opb;
      4'd1:    alu_result = rs_data - opb;
      4'd2:    alu_result = rs_data & opb;
      4'd3:    alu_result = rs_data | opb;
      4'd4:    alu_result = rs_data ^ opb;
      4'd5:    alu_result = ~(rs_data | opb);
      4'd6:    alu_result = {31'd0, $signed(rs_data) < $signed(opb)};
      4'd7:    alu_result = {31'd0, rs_data < opb};
      4'd8:    alu_result = opb << shamt;
      4'd9:    alu_result = opb >> shamt;
      4'd10:   alu_result = 32'($signed(opb) >>> shamt);
      4'd11:   alu_result = opb << 16;
      default: alu_result = 32'd0;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign write_reg = reg_dst ? rd : rt;

  // Byte address: low two bits and bits above the array size are dropped.
  assign idx              = alu_result[AW+1:2];
  assign unused_addr_bits = ^{alu_result[31:AW+2], alu_result[1:0]};
  assign mem_rdata        = mem[idx];
  assign wb_data          = memread ? mem_rdata : alu_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'd0;
    end else if (memwrite) begin
      mem[idx] <= rt_data;
    end
  end
endmodule

// File: tb/tb_mips_exec_stage.sv
// Bench for mips_exec_stage: directed test-plan vectors with literal expectations,
// then random instructions checked each cycle against a behavioural model.
module tb_mips_exec_stage;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] adr;
  logic        regwrite, memwrite, memread, branch, jump, imm_sel, reg_dst, zero;
  logic [3:0]  alu_op;
  logic [4:0]  write_reg;
  logic [31:0] alu_result, mem_rdata, wb_data;

  int compared = 0;
  int mismatched = 0;
  logic cmp_en = 1'b0;

  mips_exec_stage #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .rs_data(rs_data), .rt_data(rt_data),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .adr(adr), .regwrite(regwrite), .memwrite(memwrite), .memread(memread), .branch(branch),
    .jump(jump), .alu_op(alu_op), .imm_sel(imm_sel), .reg_dst(reg_dst), .write_reg(write_reg),
    .alu_result(alu_result), .zero(zero), .mem_rdata(mem_rdata), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        regwrite, memwrite, memread, branch, jump, imm_sel, reg_dst;
    logic [3:0]  alu_op;
    logic [31:0] result;
  } exp_t;

  logic [31:0] mdl_mem [DEPTH];

  function automatic logic [31:0] alu_model(int op, logic [31:0] a, logic [31:0] b, int sh);
    logic [31:0] r;
    case (op)
      0:  r = a + b;
      1:  r = a + (~b) + 1;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a ^ b;
      5:  r = ~a & ~b;
      6:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7:  r = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
      8:  r = b * (32'd1 << sh);
      9:  r = b / (32'd1 << sh);
      10: r = (b >> sh) | (b[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      11: r = {b[15:0], 16'h0000};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic exp_t model(logic [31:0] ins, logic [31:0] a, logic [31:0] rtv);
    exp_t e;
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    logic [31:0] ext, b;
    e = '{default: '0};
    case (op)
      0: begin
        e.reg_dst = 1; e.regwrite = 1;
        case (fn)
          'h20, 'h21: e.alu_op = 0;
          'h22, 'h23: e.alu_op = 1;
          'h24: e.alu_op = 2;  'h25: e.alu_op = 3;
          'h26: e.alu_op = 4;  'h27: e.alu_op = 5;
          'h2A: e.alu_op = 6;  'h2B: e.alu_op = 7;
          'h00: e.alu_op = 8;  'h02: e.alu_op = 9;  'h03: e.alu_op = 10;
          default: e.regwrite = 0;
        endcase
      end
      'h08, 'h09: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 0; end
      'h0A: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 6; end
      'h0B: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 7; end
      'h0C: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 2; end
      'h0D: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 3; end
      'h0E: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 4; end
      'h0F: begin e.regwrite = 1; e.imm_sel = 1; e.alu_op = 11; end
      'h23: begin e.regwrite = 1; e.memread = 1; e.imm_sel = 1; end
      'h2B: begin e.memwrite = 1; e.imm_sel = 1; end
      'h04: begin e.branch = 1; e.alu_op = 1; end
      'h02: e.jump = 1;
      default: ;
    endcase
    if (op >= 'h0C && op <= 'h0E) ext = 32'(ins[15:0]);
    else ext = 32'(signed'(ins[15:0]));
    b = e.imm_sel ? ext : rtv;
    e.result = alu_model(int'(e.alu_op), a, b, int'(ins[10:6]));
    return e;
  endfunction

  function automatic int word_of(logic [31:0] addr);
    return int'((addr >> 2) % DEPTH);
  endfunction

  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'd0;
    end else begin
      e = model(instruction, rs_data, rt_data);
      if (e.memwrite) mdl_mem[word_of(e.result)] = rt_data;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (instr %h rs %h rt %h)",
               name, act, want, instruction, rs_data, rt_data);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] rdat;
    if (cmp_en) begin
      e = model(instruction, rs_data, rt_data);
      rdat = mdl_mem[word_of(e.result)];
      check("opcode", 32'(opcode), 32'(instruction[31:26]));
      check("rs", 32'(rs), 32'(instruction[25:21]));
      check("rt", 32'(rt), 32'(instruction[20:16]));
      check("rd", 32'(rd), 32'(instruction[15:11]));
      check("shamt", 32'(shamt), 32'(instruction[10:6]));
      check("funct", 32'(funct), 32'(instruction[5:0]));
      check("imm", 32'(imm), 32'(instruction[15:0]));
      check("adr", 32'(adr), 32'(instruction[25:0]));
      check("ctrl", {25'd0, regwrite, memwrite, memread, branch, jump, imm_sel, reg_dst},
            {25'd0, e.regwrite, e.memwrite, e.memread, e.branch, e.jump, e.imm_sel, e.reg_dst});
      check("alu_op", 32'(alu_op), 32'(e.alu_op));
      check("write_reg", 32'(write_reg), e.reg_dst ? 32'(instruction[15:11]) : 32'(instruction[20:16]));
      check("alu_result", alu_result, e.result);
      check("zero", 32'(zero), (e.result == 0) ? 32'd1 : 32'd0);
      check("mem_rdata", mem_rdata, rdat);
      check("wb_data", wb_data, e.memread ? rdat : e.result);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(logic [31:0] ins, logic [31:0] a, logic [31:0] b);
    @(posedge clk);
    #1;
    instruction = ins;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] ins, a, b;
    int sel;
    int opcodes [16] = '{'h00, 'h00, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0E, 'h0F,
                         'h23, 'h2B, 'h23, 'h04, 'h02, 'h3F};
    int functs [12] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h2A, 'h2B, 'h00, 'h03};

    rst = 1'b1;
    #12;
    rst = 1'b0;
    cmp_en = 1'b1;

    // lw after reset reads zero
    drive(32'h8C000010, 32'd0, 32'd0);
    check("t1_mem_rdata", mem_rdata, 32'd0);
    check("t1_memread", 32'(memread), 32'd1);
    check("t1_wb_data", wb_data, 32'd0);

    drive(32'h20010005, 32'd0, 32'd0);
    check("t2_write_reg", 32'(write_reg), 32'd1);
    check("t2_rw_dst", {30'd0, regwrite, reg_dst}, 32'b10);
    check("t2_wb_data", wb_data, 32'd5);
    drive(32'h2001FFFF, 32'd0, 32'd0);
    check("t2_sext", alu_result, 32'hFFFFFFFF);

    drive(32'hAC220008, 32'd4, 32'hDEADBEEF);
    drive(32'h8C230008, 32'd4, 32'd0);
    check("t3_addr", alu_result, 32'd12);
    check("t3_wb_data", wb_data, 32'hDEADBEEF);
    drive(32'h8C230008, 32'd4 + 32'(4 * DEPTH), 32'd0);
    check("t3_wrap", mem_rdata, 32'hDEADBEEF);

    drive(32'h00221822, 32'd3, 32'd5);
    check("t4_sub", alu_result, 32'hFFFFFFFE);
    check("t4_write_reg", 32'(write_reg), 32'd3);
    drive(32'h0022182A, 32'd3, 32'd5);
    check("t4_slt", alu_result, 32'd1);
    drive(32'h0022182B, 32'hFFFFFFFF, 32'd1);
    check("t4_sltu", alu_result, 32'd0);
    drive(32'h00021903, 32'd0, 32'h80000000);
    check("t4_sra", alu_result, 32'hF8000000);

    drive(32'h10220003, 32'd7, 32'd7);
    check("t5_beq_eq", {29'd0, branch, zero, regwrite}, 32'b110);
    drive(32'h10220003, 32'd7, 32'd8);
    check("t5_beq_ne", 32'(zero), 32'd0);

    drive(32'h08000010, 32'd1, 32'd2);
    check("t6_jump", {30'd0, jump, regwrite | memwrite}, 32'b10);
    check("t6_adr", 32'(adr), 32'h10);
    drive(32'hFC000000, 32'd1, 32'd2);
    check("t6_nop", {23'd0, regwrite, memwrite, memread, branch, jump, imm_sel, reg_dst, |alu_op},
          32'd0);
    drive(32'h3421FFFF, 32'd0, 32'd0);
    check("t6_ori", alu_result, 32'h0000FFFF);

    // random phase; one reset pulse in the middle clears memory again
    for (int n = 0; n < 500; n++) begin
      if (n == 250) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
      end
      ins = $urandom;
      sel = $urandom_range(0, 15);
      ins[31:26] = 6'(opcodes[sel]);
      a = $urandom;
      b = $urandom;
      if (ins[31:26] == 6'h00 && $urandom_range(0, 5) != 0)
        ins[5:0] = 6'(functs[$urandom_range(0, 11)]);
      if (ins[31:26] == 6'h23 || ins[31:26] == 6'h2B) begin
        a = 32'($urandom_range(0, 15) * 4);
        if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4 * $urandom_range(1, 8));
        ins[15:0] = 16'($urandom_range(0, 15) * 4 + (($urandom_range(0, 7) == 0) ? 1 : 0));
      end
      if (ins[31:26] == 6'h04 && $urandom_range(0, 1) == 0) b = a;
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      drive(ins, a, b);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
